ultrasonic_trigger: RTL and testbench
=====================================

Name: ultrasonic_trigger

Overview:
Initiator side of the ultrasonic ranging interface. Drives the sensor TRIG pin with a fixed-width pulse and supervises the returning ECHO line with a timeout. Repeats measurements at a fixed period, or fires single shots on request. Generates the reset for the echo-width measuring receiver, so every measurement starts clean, and reports per-cycle status to the controller.

Parameters:
CNT_W, 22, width of the internal trigger/timeout/period counters.
TRIG_CYCLES, 500, TRIG high time in clk cycles (10 us at 50 MHz).
TIMEOUT_CYCLES, 1900000, max cycles from TRIG falling to ECHO falling (38 ms).
PERIOD_CYCLES, 3000000, cycles from one TRIG rise to the next in auto mode (60 ms).
Constraint: TRIG_CYCLES + TIMEOUT_CYCLES < PERIOD_CYCLES, all < 2**CNT_W.

Ports:
clk, input, 1, system clock.
rst_n, input, 1, synchronous reset, active-low.
start, input, 1, single-shot measurement request (level sampled each cycle).
auto_en, input, 1, continuous measurement mode enable.
echo, input, 1, asynchronous ECHO pin from sensor.
trig, output, 1, TRIG pin to sensor.
rcv_rst_n, output, 1, active-low reset to the echo-width receiver.
busy, output, 1, high whenever the state is not IDLE.
cycle_done, output, 1, one-cycle pulse at measurement end (ok or timeout).
status, output, 2, result of last cycle: 00 none, 01 ok, 10 no echo, 11 echo stuck.

Behaviour:
- All logic on posedge clk. All outputs registered.
- Reset values: trig=0, rcv_rst_n=0, busy=0, cycle_done=0, status=00, state IDLE, counters 0, pending=0.
- echo passes through a 2-flop synchronizer, giving echo_s. Edge flags are rise = echo_s & ~echo_s_d and fall = ~echo_s & echo_s_d.
- States: IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF.
- IDLE: if start | auto_en | pending, go to TRIG next cycle and clear pending. rcv_rst_n=1 in IDLE.
- TRIG:
  - trig=1 and rcv_rst_n=0 for exactly TRIG_CYCLES cycles.
  - The period counter is cleared on TRIG entry and counts every cycle until TRIG is next entered.
  - After TRIG_CYCLES cycles, go to WAIT_RISE and clear the timeout counter.
- WAIT_RISE:
  - On rise, go to WAIT_FALL.
  - A stale-high echo_s on entry is not a rise.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no rise: cycle_done=1, status=10, go to HOLDOFF.
- WAIT_FALL:
  - On fall: cycle_done=1, status=01, go to HOLDOFF.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 first: cycle_done=1, status=11, go to HOLDOFF.
  - The timeout counter is not cleared between WAIT_RISE and WAIT_FALL.
- HOLDOFF:
  - When the period counter reaches PERIOD_CYCLES-1, go to TRIG if auto_en | pending (clearing pending), else to IDLE.
  - In auto mode, TRIG rising edges are therefore exactly PERIOD_CYCLES apart.
- Request latching:
  - start asserted while busy=1 sets pending; it is never dropped.
  - Multiple starts during one cycle collapse to one.
  - start held high behaves like auto_en.
- auto_en deasserted mid-cycle: the current cycle completes normally; no new TRIG unless pending.
- Simultaneous fall and timeout in the same cycle: fall wins (status=01).
- rst_n low mid-operation: on the next edge trig drops to 0 and the state is IDLE; pending and status are cleared.
- busy=1 from the TRIG entry cycle through the last HOLDOFF cycle.
- cycle_done pulses once per started cycle.

Decomposition:
- Package ultrasonic_pkg holds the state encoding (3-bit localparams) and the status codes ST_NONE, ST_OK, ST_NOECHO, ST_STUCK.
- One sub-module, ultrasonic_echo_sync: 2-flop synchronizer plus delay flop, with outputs echo_s, rise, fall; reset to 0.

Test Plan:
Bench parameters: TRIG_CYCLES=4, TIMEOUT_CYCLES=20, PERIOD_CYCLES=40, CNT_W=8.
1. start pulse 1 cycle; echo high 6 cycles after trig falls, for 8 cycles -> trig high exactly 4 cycles; rcv_rst_n low during those 4; cycle_done one pulse about 2 cycles after echo falls; status=01; busy drops 40 cycles after trig rise.
2. start pulse, echo never rises -> cycle_done 20 cycles after trig falls; status=10; then IDLE.
3. start pulse, echo rises and stays high -> status=11 at timeout count 20; echo stuck high into the next start gives status=10, since a stale level is not a rise.
4. auto_en=1 for 130 cycles -> trig rising edges at cycles 0, 40, 80, 120 relative to the first; one cycle_done per period.
5. start pulses twice during busy -> exactly one extra cycle; its TRIG rises 40 cycles after the first TRIG.
6. rst_n low for 1 cycle in the middle of TRIG -> trig=0, busy=0, status=00 next cycle; no cycle_done; a fresh start works normally.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared state encoding and result codes for the ultrasonic ranging initiator.
package ultrasonic_pkg;

    localparam logic [2:0] STATE_IDLE_ENC      = 3'd0;
    localparam logic [2:0] STATE_TRIG_ENC      = 3'd1;
    localparam logic [2:0] STATE_WAIT_RISE_ENC = 3'd2;
    localparam logic [2:0] STATE_WAIT_FALL_ENC = 3'd3;
    localparam logic [2:0] STATE_HOLDOFF_ENC   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = STATE_IDLE_ENC,
        S_TRIG      = STATE_TRIG_ENC,
        S_WAIT_RISE = STATE_WAIT_RISE_ENC,
        S_WAIT_FALL = STATE_WAIT_FALL_ENC,
        S_HOLDOFF   = STATE_HOLDOFF_ENC
    } state_t;

    // Result of the most recent measurement, as reported on the status port.
    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_OK     = 2'b01;
    localparam logic [1:0] ST_NOECHO = 2'b10;
    localparam logic [1:0] ST_STUCK  = 2'b11;

endpackage

// File: rtl/ultrasonic_echo_sync.sv
// Brings the asynchronous ECHO pin into the clk domain and flags its edges.
module ultrasonic_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic meta_d;
    logic echo_s_q;
    logic echo_s_d;
    logic echo_dly_q;
    logic echo_dly_d;

    always_comb begin
        meta_d     = echo;
        echo_s_d   = meta_q;
        echo_dly_d = echo_s_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            echo_s_q   <= 1'b0;
            echo_dly_q <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            echo_s_q   <= echo_s_d;
            echo_dly_q <= echo_dly_d;
        end
    end

    // Edges compare the synchronized level against its one-cycle-old copy.
    assign echo_s = echo_s_q;
    assign rise   = echo_s_q & ~echo_dly_q;
    assign fall   = ~echo_s_q & echo_dly_q;

endmodule

// File: rtl/ultrasonic_trigger.sv
// Ultrasonic ranging initiator: fires TRIG, supervises ECHO with a timeout,
// repeats at a fixed period in auto mode and reports the outcome of each cycle.
module ultrasonic_trigger #(
    parameter int CNT_W          = 22,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int PERIOD_CYCLES  = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto_en,
    input  logic       echo,
    output logic       trig,
    output logic       rcv_rst_n,
    output logic       busy,
    output logic       cycle_done,
    output logic [1:0] status
);

    import ultrasonic_pkg::*;

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] trig_cnt_q;
    logic [CNT_W-1:0] trig_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q;
    logic [CNT_W-1:0] timeout_cnt_d;
    logic [CNT_W-1:0] period_cnt_q;
    logic [CNT_W-1:0] period_cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic             trig_q;
    logic             trig_d;
    logic             rcv_rst_n_q;
    logic             rcv_rst_n_d;
    logic             busy_q;
    logic             busy_d;
    logic             cycle_done_q;
    logic             cycle_done_d;
    logic [1:0]       status_q;
    logic [1:0]       status_d;

    logic             echo_level_unused;
    logic             echo_rise;
    logic             echo_fall;

    ultrasonic_echo_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo   (echo),
        .echo_s (echo_level_unused),
        .rise   (echo_rise),
        .fall   (echo_fall)
    );

    always_comb begin
        state_d       = state_q;
        trig_cnt_d    = trig_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        period_cnt_d  = period_cnt_q + 1'b1;
        pending_d     = pending_q | (start & busy_q);
        cycle_done_d  = 1'b0;
        status_d      = status_q;

        case (state_q)
            S_IDLE: begin
                if (start || auto_en || pending_q) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d       = S_WAIT_RISE;
                    timeout_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                timeout_cnt_d = timeout_cnt_q + 1'b1;
                if (echo_rise) begin
                    state_d = S_WAIT_FALL;
                end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    state_d      = S_HOLDOFF;
                    cycle_done_d = 1'b1;
                    status_d     = ST_NOECHO;
                end
            end
            S_WAIT_FALL: begin
                // A rise on the very last wait cycle lands here already past the limit.
                timeout_cnt_d = timeout_cnt_q + 1'b1;
                if (echo_fall) begin
                    state_d      = S_HOLDOFF;
                    cycle_done_d = 1'b1;
                    status_d     = ST_OK;
                end else if (timeout_cnt_q >= TIMEOUT_LAST) begin
                    state_d      = S_HOLDOFF;
                    cycle_done_d = 1'b1;
                    status_d     = ST_STUCK;
                end
            end
            S_HOLDOFF: begin
                if (period_cnt_q == PERIOD_LAST) begin
                    if (auto_en || pending_q || start) begin
                        state_d = S_TRIG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every TRIG entry consumes the queued request and restarts the period.
        if ((state_d == S_TRIG) && (state_q != S_TRIG)) begin
            pending_d    = 1'b0;
            period_cnt_d = '0;
            trig_cnt_d   = '0;
        end

        trig_d      = (state_d == S_TRIG);
        rcv_rst_n_d = (state_d != S_TRIG);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            trig_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            period_cnt_q  <= '0;
            pending_q     <= 1'b0;
            trig_q        <= 1'b0;
            rcv_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            cycle_done_q  <= 1'b0;
            status_q      <= ST_NONE;
        end else begin
            state_q       <= state_d;
            trig_cnt_q    <= trig_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            period_cnt_q  <= period_cnt_d;
            pending_q     <= pending_d;
            trig_q        <= trig_d;
            rcv_rst_n_q   <= rcv_rst_n_d;
            busy_q        <= busy_d;
            cycle_done_q  <= cycle_done_d;
            status_q      <= status_d;
        end
    end

    assign trig       = trig_q;
    assign rcv_rst_n  = rcv_rst_n_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;
    assign status     = status_q;

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// Bench for ultrasonic_trigger: each measurement's outcome is predicted from
// the echo pulse placement relative to the TRIG rise, then checked cycle by cycle.
module tb_ultrasonic_trigger;

    localparam int CNT_W    = 8;
    localparam int T        = 4;
    localparam int TO       = 20;
    localparam int P        = 40;
    localparam int SYNC_LAT = 3;
    localparam int NEVER    = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       auto_en;
    logic       echo;
    logic       trig;
    logic       rcv_rst_n;
    logic       busy;
    logic       cycle_done;
    logic [1:0] status;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] last_status = 2'b00;
    bit         chained;

    ultrasonic_trigger #(
        .CNT_W          (CNT_W),
        .TRIG_CYCLES    (T),
        .TIMEOUT_CYCLES (TO),
        .PERIOD_CYCLES  (P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto_en    (auto_en),
        .echo       (echo),
        .trig       (trig),
        .rcv_rst_n  (rcv_rst_n),
        .busy       (busy),
        .cycle_done (cycle_done),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Echo pin reacts in the FSM SYNC_LAT edges after it is driven; offsets are
    // relative to the TRIG rise. A rise only counts while waiting for it.
    function automatic void predict(input int ra, input int fa,
                                    output int done_off, output logic [1:0] st);
        int e;
        int f;
        int tmo;
        e = ra + SYNC_LAT;
        f = fa + SYNC_LAT;
        if (ra < 0 || e < T + 1 || e > T + TO) begin
            done_off = T + TO;
            st       = 2'b10;
        end else begin
            tmo = ((e > T + TO - 1) ? e : T + TO - 1) + 1;
            if (f <= tmo) begin
                done_off = f;
                st       = 2'b01;
            end else begin
                done_off = tmo;
                st       = 2'b11;
            end
        end
    endfunction

    task automatic checkIdle();
        checkOutput("idle_trig", trig, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_rcv_rst_n", rcv_rst_n, 1);
        checkOutput("idle_cycle_done", cycle_done, 0);
        checkOutput("idle_status", status, last_status);
    endtask

    task automatic idleCycles(input int n, input bit drop_echo);
        if (drop_echo) echo = 1'b0;
        for (int i = 0; i < n; i++) begin
            checkIdle();
            start   = 1'b0;
            auto_en = 1'b0;
            stepCycle();
        end
    endtask

    task automatic launch(input bit use_auto);
        checkIdle();
        if (use_auto) auto_en = 1'b1;
        else start = 1'b1;
        stepCycle();
    endtask

    // One measurement starting at the TRIG rise; sa/sb are start pulse offsets,
    // auto_en is held for offsets below auto_until, rst_at pulses rst_n low.
    task automatic applyStimulus(input int ra, input int fa, input int auto_until,
                                 input int sa, input int sb, input int rst_at,
                                 output bit more);
        int         done_off;
        logic [1:0] st;
        bit         aborted;
        predict(ra, fa, done_off, st);
        aborted = 1'b0;
        more    = 1'b0;
        for (int k = 0; k < P && !aborted; k++) begin
            checkOutput("trig", trig, k < T);
            checkOutput("rcv_rst_n", rcv_rst_n, k >= T);
            checkOutput("busy", busy, 1);
            checkOutput("cycle_done", cycle_done, k == done_off);
            checkOutput("status", status, (k >= done_off) ? st : last_status);
            echo    = (k >= ra) && (k < fa);
            start   = (k == sa) || (k == sb);
            auto_en = (k < auto_until);
            rst_n   = (k != rst_at);
            stepCycle();
            if (k == rst_at) begin
                checkOutput("rst_trig", trig, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_status", status, 0);
                checkOutput("rst_cycle_done", cycle_done, 0);
                checkOutput("rst_rcv_rst_n", rcv_rst_n, 0);
                rst_n       = 1'b1;
                start       = 1'b0;
                auto_en     = 1'b0;
                last_status = 2'b00;
                stepCycle();
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            last_status = st;
            more        = (auto_until >= P) || (sa >= 0) || (sb >= 0);
        end
    endtask

    task automatic pickEcho(output int ra, output int fa);
        int w;
        if (echo) begin
            ra = -NEVER;
            fa = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, P - 1));
        end else if ($urandom_range(0, 5) == 0) begin
            ra = NEVER;
            fa = NEVER;
        end else begin
            ra = $urandom_range(0, 26);
            w  = $urandom_range(1, 30);
            fa = (ra + w > P - 1) ? NEVER : ra + w;
        end
    endtask

    initial begin
        int ra;
        int fa;
        int au;
        int sa;
        int sb;
        int rst_at;
        int links;

        rst_n   = 1'b0;
        start   = 1'b0;
        auto_en = 1'b0;
        echo    = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_trig", trig, 0);
        checkOutput("reset_rcv_rst_n", rcv_rst_n, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cycle_done", cycle_done, 0);
        checkOutput("reset_status", status, 0);
        rst_n = 1'b1;
        stepCycle();
        idleCycles(2, 1'b0);

        // Single shot with a clean echo pulse, then no echo at all.
        launch(1'b0);
        applyStimulus(10, 18, 0, -1, -1, -1, chained);
        idleCycles(3, 1'b0);
        launch(1'b0);
        applyStimulus(NEVER, NEVER, 0, -1, -1, -1, chained);
        idleCycles(3, 1'b0);

        // Echo stuck high, then carried stale into the next shot.
        launch(1'b0);
        applyStimulus(10, NEVER, 0, -1, -1, -1, chained);
        idleCycles(3, 1'b0);
        launch(1'b0);
        applyStimulus(-NEVER, NEVER, 0, -1, -1, -1, chained);
        idleCycles(4, 1'b1);

        // Auto mode for three periods, dropped mid-way through the fourth.
        launch(1'b1);
        applyStimulus(10, 18, P, -1, -1, -1, chained);
        applyStimulus(5, 12, P, -1, -1, -1, chained);
        applyStimulus(3, 30, P, -1, -1, -1, chained);
        applyStimulus(8, 12, 20, -1, -1, -1, chained);
        idleCycles(3, 1'b0);

        // Two starts while busy collapse into exactly one extra measurement.
        launch(1'b0);
        applyStimulus(10, 18, 0, 12, 30, -1, chained);
        applyStimulus(10, 18, 0, -1, -1, -1, chained);
        idleCycles(3, 1'b0);

        // Reset in the middle of TRIG, then a fresh shot.
        launch(1'b0);
        applyStimulus(NEVER, NEVER, 0, -1, -1, 2, chained);
        idleCycles(3, 1'b0);
        launch(1'b0);
        applyStimulus(10, 18, 0, -1, -1, -1, chained);
        idleCycles(2, 1'b0);

        // Timing edges: last rise slot, first late rise, fall/timeout tie,
        // rise during TRIG, first usable rise slot, start on the final cycle.
        launch(1'b0);
        applyStimulus(21, 25, 0, -1, -1, -1, chained);
        idleCycles(4, 1'b1);
        launch(1'b0);
        applyStimulus(22, 30, 0, -1, -1, -1, chained);
        idleCycles(4, 1'b1);
        launch(1'b0);
        applyStimulus(10, 21, 0, -1, -1, -1, chained);
        idleCycles(4, 1'b1);
        launch(1'b0);
        applyStimulus(1, 10, 0, -1, -1, -1, chained);
        idleCycles(4, 1'b1);
        launch(1'b0);
        applyStimulus(2, 9, 0, P - 1, -1, -1, chained);
        applyStimulus(NEVER, NEVER, 0, -1, -1, -1, chained);
        idleCycles(2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            links = 0;
            launch($urandom_range(0, 1) == 1);
            do begin
                pickEcho(ra, fa);
                rst_at = -1;
                sa     = -1;
                sb     = -1;
                au     = 0;
                if (!echo && $urandom_range(0, 7) == 0) begin
                    ra     = NEVER;
                    fa     = NEVER;
                    rst_at = $urandom_range(0, T - 1);
                end else if (links < 3) begin
                    case ($urandom_range(0, 4))
                        0: au = P;
                        1: au = $urandom_range(1, P - 1);
                        2: sa = $urandom_range(0, P - 1);
                        3: begin
                            sa = $urandom_range(0, P - 1);
                            sb = $urandom_range(0, P - 1);
                        end
                        default: au = 0;
                    endcase
                end
                applyStimulus(ra, fa, au, sa, sb, rst_at, chained);
                links++;
            end while (chained);
            idleCycles($urandom_range(1, 4), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
